pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Parametrised stall/flush/advance controller for the pipelined MIPS datapath; generalises the single global ihit latch-enable to an N-latch pipeline.
- Adds the following:
  - Decoupled imem/dmem completion tracking.
  - Load-use bubble insertion.
  - Branch flush at a configurable resolve latch.
  - Sticky halt.
- Sits beside the datapath and drives per-latch enable/flush, PC enable and dmem request gating.

Parameters:
- NLATCH, 4: number of pipeline latches (IF/ID=0 ... MEM/WB=NLATCH-1); minimum 4.
- BR_LATCH, 2: latch whose output resolves branches/jumps; range 1..NLATCH-2.
- MEM_LATCH, 2: latch whose output drives the data memory; range 1..NLATCH-2.
- CNT_W, 32: width of performance counters (optional feature only).

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- nRST, input, 1: synchronous, active-high reset (1 = reset; sampled on the CLK rising edge).
- ihit, input, 1: instruction fetch complete this cycle.
- dhit, input, 1: data access complete this cycle.
- mem_req, input, 1: instruction in MEM_LATCH issues dREN or dWEN.
- ex_load, input, 1: instruction in latch 1 (ID/EX) is a load.
- ex_rt, input, 5: destination register of that load.
- id_rs, input, 5: rs of instruction in latch 0.
- id_rt, input, 5: rt of instruction in latch 0.
- id_use_rt, input, 1: latch-0 instruction reads rt.
- br_taken, input, 1: BR_LATCH instruction redirects PC.
- halt_in, input, 1: instruction in latch NLATCH-1 is HALT.
- lat_en, output, NLATCH: per-latch load enable.
- lat_flush, output, NLATCH: per-latch bubble load (latch loads zeros, valid cleared); only meaningful with lat_en.
- valid, output, NLATCH: per-latch valid bits.
- pc_en, output, 1: PC register load enable.
- pc_redirect, output, 1: select redirect target instead of pc+4.
- dmem_gate, output, 1: qualifies dmemREN/dmemWEN.
- halt, output, 1: sticky CPU halt.
- state, output, 2: FSM state (encoding from package).

Behaviour:
- Reset: all of the following are cleared on the next edge regardless of ihit/dhit, including mid-WAIT:
  - valid=0, state=RUN, halt=0, i_done=0, d_done=0.
  - All outputs 0 except state=RUN.
- Completion flags:
  - i_ok = ihit | i_done.
  - d_need = valid[MEM_LATCH] & mem_req.
  - d_ok = ~d_need | dhit | d_done.
  - i_done sets on ihit while not advancing.
  - d_done sets on dhit while not advancing.
  - Both flags clear on advance.
- advance = (state != HALTED) & i_ok & d_ok. Combinational, zero latency.
- FSM:
  - RUN -> WAIT when ~advance and not halted.
  - WAIT -> RUN on advance.
  - Any state -> HALTED when advance & valid[NLATCH-1] & halt_in.
  - HALTED is absorbing until reset.
- dmem_gate = d_need & ~d_done & ~dhit (request dropped in the hit cycle and afterwards).
- Not advancing: lat_en=0, pc_en=0, valid holds.
- Advancing, no hazard:
  - lat_en=all 1, pc_en=1.
  - valid[k] <= valid[k-1]; valid[0] <= 1.
- Load-use:
  - Condition: lu = valid[1] & ex_load & ex_rt!=0 & valid[0] & (ex_rt==id_rs | (id_use_rt & ex_rt==id_rt)).
  - On advance & lu: lat_en[0]=0, pc_en=0, lat_flush[1]=1 (bubble into latch 1); latches >=2 advance.
- Branch:
  - Condition: br = valid[BR_LATCH] & br_taken.
  - On advance & br: pc_en=1, pc_redirect=1, lat_flush[0..BR_LATCH]=1 (younger work squashed, valid cleared).
- Priority: halt > branch > load-use. Branch and load-use in the same cycle: the flush wins and no lu stall is applied.
- halt <= halt | (advance & valid[NLATCH-1] & halt_in). Once set: lat_en=0, pc_en=0, dmem_gate=0.
- Events in WAIT: br_taken and lu are acted on only in the advance cycle.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined, adds outputs cnt_stall, cnt_bubble and cnt_flush, each CNT_W wide:
  - cnt_stall increments each non-advancing non-halted cycle.
  - cnt_bubble increments on each load-use bubble.
  - cnt_flush increments on each branch flush.
  - All three saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to dp_types_pkg:
  - ctrl_state_t enum {RUN=2'd0, WAIT=2'd1, HALTED=2'd2}.
  - Hazard priority localparams.
- Sub-module hazard_detect: purely the lu/br conditions. It is combinational and instantiated once; all sequencing stays in pipeline_ctrl.

Test Plan:
- Reset then ihit=1 every cycle for 5 cycles -> valid goes 0001, 0011, 0111, 1111; pc_en=1 throughout; state=RUN.
- mem_req=1 at MEM_LATCH, dhit low 3 cycles, ihit pulses in cycle 1 only -> state=WAIT, lat_en=0 for 3 cycles, dmem_gate=1 until dhit. Advance occurs in the dhit cycle with i_done satisfying fetch.
- ex_load=1, ex_rt=5, id_rs=5 -> one cycle with lat_en[0]=0, pc_en=0, lat_flush[1]=1, valid[1]=0 next. Same with ex_rt=0 -> no stall.
- br_taken=1 at BR_LATCH=2 plus simultaneous load-use -> pc_redirect=1, lat_flush=0111, no lu stall; valid[0..2]=0 next cycle.
- halt_in with valid[3]=1 on advance -> halt=1 next edge; it stays 1 with ihit toggling; lat_en=0, pc_en=0.
- nRST=1 asserted during WAIT with dhit=0 -> next edge: valid=0, state=RUN, halt=0, flags cleared. With PIPELINE_CTRL_PERF_EN, cnt_stall=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/advance controller.
// The controller FSM encoding, the hazard actions and their priority live here.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // Hazard priority: a higher number wins when several hazards coincide.
    localparam int unsigned HZ_PRI_NONE    = 0;
    localparam int unsigned HZ_PRI_LOADUSE = 1;
    localparam int unsigned HZ_PRI_BRANCH  = 2;
    localparam int unsigned HZ_PRI_HALT    = 3;

    // The action chosen for an advancing cycle; encodings track the priorities.
    typedef enum logic [1:0] {
        ACT_NONE = 2'(HZ_PRI_NONE),
        ACT_LU   = 2'(HZ_PRI_LOADUSE),
        ACT_BR   = 2'(HZ_PRI_BRANCH),
        ACT_HALT = 2'(HZ_PRI_HALT)
    } hz_act_t;

    // Pick the single highest-priority hazard: halt > branch > load-use.
    function automatic hz_act_t hz_select(input logic halt_ev, input logic br, input logic lu);
        hz_act_t act;
        act = ACT_NONE;
        if (halt_ev) begin
            act = ACT_HALT;
        end else if (br) begin
            act = ACT_BR;
        end else if (lu) begin
            act = ACT_LU;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the pipeline controller.
// master = controller side (consumes status, drives latch/PC/dmem control),
// slave  = datapath side.
interface pipeline_ctrl_if #(
    parameter int NLATCH = 4
);
    import pipeline_ctrl_pkg::*;

    // Datapath status
    logic              ihit;
    logic              dhit;
    logic              mem_req;
    logic              ex_load;
    logic [4:0]        ex_rt;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_use_rt;
    logic              br_taken;
    logic              halt_in;

    // Controller outputs
    logic [NLATCH-1:0] lat_en;
    logic [NLATCH-1:0] lat_flush;
    logic [NLATCH-1:0] valid;
    logic              pc_en;
    logic              pc_redirect;
    logic              dmem_gate;
    logic              halt;
    ctrl_state_t       state;

    modport master (
        input  ihit, dhit, mem_req, ex_load, ex_rt, id_rs, id_rt, id_use_rt, br_taken, halt_in,
        output lat_en, lat_flush, valid, pc_en, pc_redirect, dmem_gate, halt, state
    );

    modport slave (
        output ihit, dhit, mem_req, ex_load, ex_rt, id_rs, id_rt, id_use_rt, br_taken, halt_in,
        input  lat_en, lat_flush, valid, pc_en, pc_redirect, dmem_gate, halt, state
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch detection for the pipeline controller.
// Only raw conditions are produced here; priority and sequencing are the caller's.
module hazard_detect (
    input  logic       valid_id,
    input  logic       valid_ex,
    input  logic       valid_br,
    input  logic       ex_load,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    input  logic       br_taken,
    output logic       lu,
    output logic       br
);

    // A load into $0 never creates a dependency, so rt==0 is excluded.
    always_comb begin
        lu = valid_ex & ex_load & (ex_rt != 5'd0) & valid_id &
             ((ex_rt == id_rs) | (id_use_rt & (ex_rt == id_rt)));
        br = valid_br & br_taken;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/advance controller for an NLATCH-deep pipeline.
// Tracks imem/dmem completion separately, inserts load-use bubbles, squashes
// younger work on a taken branch at BR_LATCH, and latches a sticky halt.
// Optional build macro: PIPELINE_CTRL_PERF_EN adds saturating stall/bubble/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NLATCH    = 4,
    parameter int BR_LATCH  = 2,
    parameter int MEM_LATCH = 2,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    pipeline_ctrl_if.master  bus
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_bubble,
    output logic [CNT_W-1:0] cnt_flush
`endif
);

    // Unsupported configurations stop elaboration.
    if (NLATCH < 4 || BR_LATCH < 1 || BR_LATCH > NLATCH - 2 ||
        MEM_LATCH < 1 || MEM_LATCH > NLATCH - 2 || CNT_W < 1) begin : g_bad_params
        $error("pipeline_ctrl: parameter out of range");
    end

    // Latches 0..BR_LATCH hold work younger than the resolving branch.
    localparam logic [NLATCH-1:0] BR_MASK = NLATCH'((1 << (BR_LATCH + 1)) - 1);

    ctrl_state_t       state_q, state_d;
    logic [NLATCH-1:0] valid_q, valid_d, shift_in;
    logic [NLATCH-1:0] en_d, flush_d;
    logic              halt_q, i_done_q, d_done_q;
    logic              i_ok, d_need, d_ok, advance, halt_ev;
    logic              pc_en_d, redir_d;
    logic              lu, br;
    hz_act_t           act;

    hazard_detect u_hazard (
        .valid_id  (valid_q[0]),
        .valid_ex  (valid_q[1]),
        .valid_br  (valid_q[BR_LATCH]),
        .ex_load   (bus.ex_load),
        .ex_rt     (bus.ex_rt),
        .id_rs     (bus.id_rs),
        .id_rt     (bus.id_rt),
        .id_use_rt (bus.id_use_rt),
        .br_taken  (bus.br_taken),
        .lu        (lu),
        .br        (br)
    );

    // Completion tracking: an early hit is remembered until the pipeline moves.
    always_comb begin
        i_ok    = bus.ihit | i_done_q;
        d_need  = valid_q[MEM_LATCH] & bus.mem_req;
        d_ok    = ~d_need | bus.dhit | d_done_q;
        advance = (state_q != HALTED) & i_ok & d_ok;
        halt_ev = advance & valid_q[NLATCH-1] & bus.halt_in;
        act     = hz_select(halt_ev, br, lu);
    end

    // Latch/PC control for this cycle; the halting cycle freezes everything.
    always_comb begin
        en_d    = '0;
        flush_d = '0;
        pc_en_d = 1'b0;
        redir_d = 1'b0;
        if (advance) begin
            case (act)
                ACT_HALT: begin
                end
                ACT_BR: begin
                    en_d    = '1;
                    pc_en_d = 1'b1;
                    redir_d = 1'b1;
                    flush_d = BR_MASK;
                end
                ACT_LU: begin
                    en_d    = ~NLATCH'(1);
                    flush_d = NLATCH'(2);
                end
                default: begin
                    en_d    = '1;
                    pc_en_d = 1'b1;
                end
            endcase
        end
    end

    // Valid bits follow the latches: loaded latches take the older bit (or 0 when flushed).
    always_comb begin
        shift_in = {valid_q[NLATCH-2:0], 1'b1};
        valid_d  = valid_q;
        for (int k = 0; k < NLATCH; k++) begin
            if (en_d[k]) begin
                valid_d[k] = shift_in[k] & ~flush_d[k];
            end
        end
    end

    // FSM next state: WAIT while stalled, HALTED absorbing until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_ev)       state_d = HALTED;
                else if (!advance) state_d = WAIT;
            end
            WAIT: begin
                if (halt_ev)      state_d = HALTED;
                else if (advance) state_d = RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State, valid, halt and completion-flag registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q  <= RUN;
            valid_q  <= '0;
            halt_q   <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            halt_q   <= halt_q | halt_ev;
            i_done_q <= advance ? 1'b0 : (i_done_q | bus.ihit);
            d_done_q <= advance ? 1'b0 : (d_done_q | bus.dhit);
        end
    end

    // The dmem request drops in the hit cycle, stays down once done, and never after halt.
    assign bus.dmem_gate   = d_need & ~d_done_q & ~bus.dhit & ~halt_q;
    assign bus.lat_en      = en_d;
    assign bus.lat_flush   = flush_d;
    assign bus.valid       = valid_q;
    assign bus.pc_en       = pc_en_d;
    assign bus.pc_redirect = redir_d;
    assign bus.halt        = halt_q;
    assign bus.state       = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    // Saturating event counters.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            cnt_stall  <= '0;
            cnt_bubble <= '0;
            cnt_flush  <= '0;
        end else begin
            if (!advance && state_q != HALTED && cnt_stall != '1)
                cnt_stall <= cnt_stall + CNT_W'(1);
            if (advance && act == ACT_LU && cnt_bubble != '1)
                cnt_bubble <= cnt_bubble + CNT_W'(1);
            if (advance && act == ACT_BR && cnt_flush != '1)
                cnt_flush <= cnt_flush + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (NLATCH=4, BR_LATCH=2, MEM_LATCH=2).
// Each driven cycle pushes a hand-computed output vector; a monitor pops and
// compares on the falling edge.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int W = 26;  // {id[7:0], st[1:0], halt, gate, redir, pc_en, valid[3:0], flush[3:0], en[3:0]}

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  pipeline_ctrl_if #(.NLATCH(4)) bus ();

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] cnt_stall, cnt_bubble, cnt_flush;
`endif

  pipeline_ctrl #(
    .NLATCH(4), .BR_LATCH(2), .MEM_LATCH(2), .CNT_W(32)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.master)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .cnt_stall (cnt_stall),
    .cnt_bubble(cnt_bubble),
    .cnt_flush (cnt_flush)
`endif
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // driver tasks
  task automatic set_idle();
    nRST          = 1'b0;
    bus.ihit      = 1'b0;
    bus.dhit      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.ex_load   = 1'b0;
    bus.ex_rt     = 5'd0;
    bus.id_rs     = 5'd0;
    bus.id_rt     = 5'd0;
    bus.id_use_rt = 1'b0;
    bus.br_taken  = 1'b0;
    bus.halt_in   = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    set_idle();
  endtask

  task automatic ex(input int id, input logic [1:0] st, input logic hl, input logic gt,
                    input logic rd, input logic pc, input logic [3:0] v,
                    input logic [3:0] f, input logic [3:0] e);
    exp_q.push_back({8'(id), st, hl, gt, rd, pc, v, f, e});
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v;
    logic [17:0]  act_v;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {2'(bus.state), bus.halt, bus.dmem_gate, bus.pc_redirect, bus.pc_en,
                 bus.valid, bus.lat_flush, bus.lat_en};
        checks++;
        if (act_v !== exp_v[17:0]) begin
          errors++;
          $display("FAIL vec%0d: got st=%0d halt=%b gate=%b redir=%b pc_en=%b valid=%b flush=%b en=%b ; exp st=%0d halt=%b gate=%b redir=%b pc_en=%b valid=%b flush=%b en=%b",
                   exp_v[25:18], act_v[17:16], act_v[15], act_v[14], act_v[13], act_v[12],
                   act_v[11:8], act_v[7:4], act_v[3:0], exp_v[17:16], exp_v[15], exp_v[14],
                   exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
  end

  // stimulus: vectors with hand-computed expectations
  initial begin
    set_idle();
    nRST = 1'b1;

    // reset
    tick(); nRST = 1'b1;                     ex(0, 0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000);

    // fill: valid 0000 -> 0001 -> 0011 -> 0111 -> 1111
    tick(); bus.ihit = 1;                    ex(1, 0,0,0,0,1, 4'b0000, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(2, 0,0,0,0,1, 4'b0001, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(3, 0,0,0,0,1, 4'b0011, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(4, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(5, 0,0,0,0,1, 4'b1111, 4'b0000, 4'b1111);

    // dmem stall with early ihit; advance in dhit cycle
    tick(); bus.ihit = 1; bus.mem_req = 1;   ex(6, 0,0,1,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1;                 ex(7, 1,0,1,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1;                 ex(8, 1,0,1,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1; bus.dhit = 1;   ex(9, 1,0,0,0,1, 4'b1111, 4'b0000, 4'b1111);
    // i_done must have cleared on that advance
    tick();                                  ex(10, 0,0,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.ihit = 1;                    ex(11, 1,0,0,0,1, 4'b1111, 4'b0000, 4'b1111);
    // early dhit remembered while fetch is outstanding
    tick(); bus.mem_req = 1; bus.dhit = 1;   ex(12, 0,0,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1;                 ex(13, 1,0,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1; bus.ihit = 1;   ex(14, 1,0,0,0,1, 4'b1111, 4'b0000, 4'b1111);

    // load-use on rs
    tick(); bus.ihit = 1; bus.ex_load = 1; bus.ex_rt = 5; bus.id_rs = 5;
                                             ex(15, 0,0,0,0,0, 4'b1111, 4'b0010, 4'b1110);
    tick(); bus.ihit = 1;                    ex(16, 0,0,0,0,1, 4'b1101, 4'b0000, 4'b1111);
    // load into $0: no stall
    tick(); bus.ihit = 1; bus.ex_load = 1; bus.ex_rt = 0; bus.id_rs = 0;
                                             ex(17, 0,0,0,0,1, 4'b1011, 4'b0000, 4'b1111);
    // rt match but rt not read: no stall
    tick(); bus.ihit = 1; bus.ex_load = 1; bus.ex_rt = 7; bus.id_rs = 3; bus.id_rt = 7;
                                             ex(18, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);
    // rt match and rt read: stall
    tick(); bus.ihit = 1; bus.ex_load = 1; bus.ex_rt = 7; bus.id_rs = 3; bus.id_rt = 7; bus.id_use_rt = 1;
                                             ex(19, 0,0,0,0,0, 4'b1111, 4'b0010, 4'b1110);
    tick(); bus.ihit = 1;                    ex(20, 0,0,0,0,1, 4'b1101, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(21, 0,0,0,0,1, 4'b1011, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(22, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);

    // branch together with load-use: flush wins
    tick(); bus.ihit = 1; bus.br_taken = 1; bus.ex_load = 1; bus.ex_rt = 5; bus.id_rs = 5;
                                             ex(23, 0,0,0,1,1, 4'b1111, 4'b0111, 4'b1111);
    // br_taken with valid[2]=0 ignored
    tick(); bus.ihit = 1; bus.br_taken = 1;  ex(24, 0,0,0,0,1, 4'b1000, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(25, 0,0,0,0,1, 4'b0001, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(26, 0,0,0,0,1, 4'b0011, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(27, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);
    // branch seen while stalled acts only on the advance cycle
    tick(); bus.br_taken = 1;                ex(28, 0,0,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.ihit = 1; bus.br_taken = 1;  ex(29, 1,0,0,1,1, 4'b1111, 4'b0111, 4'b1111);
    tick(); bus.ihit = 1;                    ex(30, 0,0,0,0,1, 4'b1000, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(31, 0,0,0,0,1, 4'b0001, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(32, 0,0,0,0,1, 4'b0011, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(33, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);

    // reset in WAIT with dhit low
    tick(); bus.mem_req = 1;                 ex(34, 0,0,1,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1; nRST = 1;       ex(35, 1,0,1,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.mem_req = 1;                 ex(36, 0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000);
`ifdef PIPELINE_CTRL_PERF_EN
    checks++;
    if (cnt_stall !== 32'd0) begin
      errors++;
      $display("FAIL cnt_stall_after_reset: got %0d exp 0", cnt_stall);
    end
`endif
    tick(); bus.ihit = 1;                    ex(37, 1,0,0,0,1, 4'b0000, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(38, 0,0,0,0,1, 4'b0001, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(39, 0,0,0,0,1, 4'b0011, 4'b0000, 4'b1111);
    tick(); bus.ihit = 1;                    ex(40, 0,0,0,0,1, 4'b0111, 4'b0000, 4'b1111);

    // halt: freeze on the halting advance, then sticky
    tick(); bus.ihit = 1; bus.halt_in = 1;   ex(41, 0,0,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.halt_in = 1; bus.mem_req = 1;ex(42, 2,1,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.ihit = 1; bus.br_taken = 1;  ex(43, 2,1,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); bus.dhit = 1;                    ex(44, 2,1,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick(); nRST = 1;                        ex(45, 2,1,0,0,0, 4'b1111, 4'b0000, 4'b0000);
    tick();                                  ex(46, 0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000);
    tick(); bus.ihit = 1;                    ex(47, 1,0,0,0,1, 4'b0000, 4'b0000, 4'b1111);

    // drain with a bounded wait
    tick();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
